// File: rtl/shuffler_sched.sv
// Sequencing controller for the Stripes brick shuffler: accepts shuffle commands,
// issues one select pattern per available source set, and tracks passes through the shuffler latency.
module shuffler_sched #(
    parameter int IN_BRICKS  = 16,
    parameter int OUT_BRICKS = 16,
    parameter int SEL_BITS   = 4,
    parameter int PASS_BITS  = 8,
    parameter int SHUF_LAT   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_mode,
    input  logic [SEL_BITS-1:0]            cmd_offset,
    input  logic [SEL_BITS-1:0]            cmd_step,
    input  logic [PASS_BITS-1:0]           cmd_passes,
    input  logic                           src_valid,
    output logic                           src_rd,
    output logic [SEL_BITS*OUT_BRICKS-1:0] o_sel,
    output logic                           o_valid,
    output logic                           o_last,
    output logic [PASS_BITS-1:0]           o_tag,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                        state;
    logic                          mode_r;
    logic [SEL_BITS-1:0]           off_r;
    logic [SEL_BITS-1:0]           step_r;
    logic [PASS_BITS-1:0]          passes_r;
    logic [PASS_BITS-1:0]          cnt_r;
    logic [SEL_BITS*OUT_BRICKS-1:0] sel_comb;
    logic [SEL_BITS*OUT_BRICKS-1:0] sel_hold;
    logic                          issue;
    logic                          is_last;
    logic                          upper_empty;

    logic                          vld_p  [SHUF_LAT];
    logic                          last_p [SHUF_LAT];
    logic [PASS_BITS-1:0]          tag_p  [SHUF_LAT];

    assign issue     = (state == RUN) && src_valid;
    assign is_last   = (cnt_r == passes_r);
    assign src_rd    = issue;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign o_sel     = (state == RUN) ? sel_comb : sel_hold;

    always_comb begin
        sel_comb = '0;
        for (int i = 0; i < OUT_BRICKS; i++) begin
            sel_comb[i*SEL_BITS +: SEL_BITS] = mode_r ? off_r
                                             : SEL_BITS'((int'(off_r) + i) % IN_BRICKS);
        end
    end

    // Stages ahead of the output stage are empty: the next cycle shows no valid pass.
    always_comb begin
        upper_empty = 1'b1;
        for (int s = 0; s < SHUF_LAT - 1; s++) begin
            if (vld_p[s]) upper_empty = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_r   <= 1'b0;
            off_r    <= '0;
            step_r   <= '0;
            passes_r <= '0;
            cnt_r    <= '0;
            sel_hold <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN) sel_hold <= sel_comb;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        mode_r   <= cmd_mode;
                        off_r    <= cmd_offset;
                        step_r   <= cmd_step;
                        passes_r <= cmd_passes;
                        cnt_r    <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        off_r <= off_r + step_r;
                        cnt_r <= cnt_r + PASS_BITS'(1);
                        if (is_last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done) state <= IDLE;
                    else if (upper_empty) done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delay pipeline: stage 0 captures the issue, final stage lines up with shuffler output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SHUF_LAT; s++) begin
                vld_p[s]  <= 1'b0;
                last_p[s] <= 1'b0;
                tag_p[s]  <= '0;
            end
        end else begin
            vld_p[0]  <= issue;
            last_p[0] <= issue && is_last;
            tag_p[0]  <= cnt_r;
            for (int s = 1; s < SHUF_LAT; s++) begin
                vld_p[s]  <= vld_p[s-1];
                last_p[s] <= last_p[s-1];
                tag_p[s]  <= tag_p[s-1];
            end
        end
    end

    assign o_valid = vld_p[SHUF_LAT-1];
    assign o_last  = last_p[SHUF_LAT-1];
    assign o_tag   = tag_p[SHUF_LAT-1];

endmodule

// File: tb/tb_shuffler_sched.sv
// Bench for shuffler_sched: a cycle model predicts handshakes, selects and a scoreboard
// of pass results due SHUF_LAT cycles after each issue; scenario tasks check recorded timing.
module tb_shuffler_sched;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_mode = 1'b0;
    logic [3:0]  cmd_offset = '0;
    logic [3:0]  cmd_step = '0;
    logic [7:0]  cmd_passes = '0;
    logic        src_valid = 1'b0;
    logic        src_rd;
    logic [63:0] o_sel;
    logic        o_valid;
    logic        o_last;
    logic [7:0]  o_tag;
    logic        busy;
    logic        done;

    shuffler_sched dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_offset(cmd_offset), .cmd_step(cmd_step),
        .cmd_passes(cmd_passes), .src_valid(src_valid), .src_rd(src_rd), .o_sel(o_sel),
        .o_valid(o_valid), .o_last(o_last), .o_tag(o_tag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // command fields applied at the start of the next cycle
    logic       nx_mode = 1'b0;
    logic [3:0] nx_off  = '0;
    logic [3:0] nx_step = '0;
    logic [7:0] nx_pass = '0;

    // reference model
    int         m_st = 0;
    logic       m_mode = 1'b0;
    logic [3:0] m_off = '0;
    logic [3:0] m_step = '0;
    logic [7:0] m_cnt = '0;
    logic [7:0] m_passes = '0;
    int         m_done_due = -1;
    int         m_acc = 0;

    typedef struct {
        int         due;
        logic [7:0] tag;
        logic       last;
    } exp_t;
    exp_t sbq[$];

    // observations for per-scenario timing checks
    int         rd_q[$];
    int         vld_q[$];
    int         last_q[$];
    int         done_q[$];
    logic [3:0] sel0_q[$];
    logic [3:0] sel15_q[$];
    logic [7:0] tag_q[$];

    task automatic clear_obs();
        rd_q.delete(); vld_q.delete(); last_q.delete(); done_q.delete();
        sel0_q.delete(); sel15_q.delete(); tag_q.delete();
    endtask

    task automatic cycle(input logic sv, input logic cv, input logic r);
        logic        exp_rd;
        logic        exp_done;
        logic [63:0] ev;
        exp_t        e;
        @(posedge clk);
        #1;
        cyc++;
        src_valid  = sv;
        cmd_valid  = cv;
        rst_n      = ~r;
        cmd_mode   = nx_mode;
        cmd_offset = nx_off;
        cmd_step   = nx_step;
        cmd_passes = nx_pass;
        @(negedge clk);

        if (src_rd === 1'b1) begin
            rd_q.push_back(cyc); sel0_q.push_back(o_sel[3:0]); sel15_q.push_back(o_sel[63:60]);
        end
        if (o_valid === 1'b1) begin
            vld_q.push_back(cyc); tag_q.push_back(o_tag);
            if (o_last === 1'b1) last_q.push_back(cyc);
        end
        if (done === 1'b1) done_q.push_back(cyc);

        n_tests++;
        if (cmd_ready !== (m_st == 0) || busy !== (m_st != 0)) begin
            n_fail++;
            $display("FAIL handshake cyc=%0d: ready=%b busy=%b, want ready=%b busy=%b",
                     cyc, cmd_ready, busy, (m_st == 0), (m_st != 0));
        end

        exp_rd = (m_st == 1) && sv;
        n_tests++;
        if (src_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL src_rd cyc=%0d: got %b want %b", cyc, src_rd, exp_rd);
        end

        if (exp_rd) begin
            for (int i = 0; i < 16; i++) ev[i*4 +: 4] = m_mode ? m_off : 4'(m_off + 4'(i));
            n_tests++;
            if (o_sel !== ev) begin
                n_fail++;
                $display("FAIL o_sel cyc=%0d: got %h want %h", cyc, o_sel, ev);
            end
        end

        n_tests++;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            if (o_valid !== 1'b1 || o_tag !== e.tag || o_last !== e.last) begin
                n_fail++;
                $display("FAIL out_pass cyc=%0d: valid=%b tag=%0d last=%b, want valid=1 tag=%0d last=%b",
                         cyc, o_valid, o_tag, o_last, e.tag, e.last);
            end
        end else if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL out_idle cyc=%0d: o_valid=%b want 0", cyc, o_valid);
        end

        exp_done = (cyc == m_done_due);
        n_tests++;
        if (done !== exp_done) begin
            n_fail++;
            $display("FAIL done cyc=%0d: got %b want %b", cyc, done, exp_done);
        end

        case (m_st)
            0: if (cv) begin
                m_mode = cmd_mode; m_off = cmd_offset; m_step = cmd_step;
                m_passes = cmd_passes; m_cnt = '0; m_st = 1; m_acc++;
            end
            1: if (exp_rd) begin
                e.due = cyc + LAT; e.tag = m_cnt; e.last = (m_cnt == m_passes);
                sbq.push_back(e);
                if (e.last) begin
                    m_st = 2; m_done_due = cyc + LAT + 1;
                end
                m_off = m_off + m_step;
                m_cnt = m_cnt + 8'd1;
            end
            2: if (cyc == m_done_due) m_st = 0;
            default: m_st = 0;
        endcase
        if (r) begin
            m_st = 0; m_off = '0; m_step = '0; m_cnt = '0; m_done_due = -1;
            sbq.delete();
        end
    endtask

    task automatic set_cmd(input logic md, input logic [3:0] off, input logic [3:0] st,
                           input logic [7:0] ps);
        nx_mode = md; nx_off = off; nx_step = st; nx_pass = ps;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (o_sel !== 64'd0 || o_valid !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: sel=%h valid=%b done=%b ready=%b busy=%b, want 0 0 0 1 0",
                     o_sel, o_valid, done, cmd_ready, busy);
        end
    endtask

    task automatic test_rotate();
        int a;
        int exp_sel0[4]  = '{3, 4, 5, 6};
        int exp_sel15[4] = '{2, 3, 4, 5};
        clear_obs();
        set_cmd(1'b0, 4'd3, 4'd1, 8'd3);
        a = cyc + 1;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (rd_q.size() != 4 || vld_q.size() != 4) begin
            n_fail++;
            $display("FAIL rot_counts: rd=%0d vld=%0d want 4 4", rd_q.size(), vld_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (rd_q[i] != a + 1 + i || 32'(sel0_q[i]) != exp_sel0[i] || 32'(sel15_q[i]) != exp_sel15[i]
                    || vld_q[i] != a + 3 + i || 32'(tag_q[i]) != i) begin
                    n_fail++;
                    $display("FAIL rot_pass%0d: rd@%0d sel0=%0d sel15=%0d vld@%0d tag=%0d, want rd@%0d %0d %0d vld@%0d tag=%0d",
                             i, rd_q[i] - a, sel0_q[i], sel15_q[i], vld_q[i] - a, tag_q[i],
                             1 + i, exp_sel0[i], exp_sel15[i], 3 + i, i);
                end
            end
        end
        n_tests++;
        if (last_q.size() != 1 || done_q.size() != 1 || last_q[0] != a + 6 || done_q[0] != a + 7) begin
            n_fail++;
            $display("FAIL rot_last_done: nlast=%0d ndone=%0d, want last@6 done@7", last_q.size(), done_q.size());
        end
    endtask

    task automatic test_wrap_bcast();
        int exp_sel[3] = '{14, 1, 4};
        clear_obs();
        set_cmd(1'b1, 4'd14, 4'd3, 8'd2);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (vld_q.size() != 3 || rd_q.size() != 3) begin
            n_fail++;
            $display("FAIL bc_count: vld=%0d rd=%0d want 3 3", vld_q.size(), rd_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (32'(sel0_q[i]) != exp_sel[i] || 32'(sel15_q[i]) != exp_sel[i]) begin
                    n_fail++;
                    $display("FAIL bc_sel%0d: lane0=%0d lane15=%0d want %0d", i, sel0_q[i], sel15_q[i], exp_sel[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int a;
        logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        clear_obs();
        set_cmd(1'b0, 4'd5, 4'd2, 8'd1);
        a = cyc + 1;
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(pat[i], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (rd_q.size() != 2 || vld_q.size() != 2) begin
            n_fail++;
            $display("FAIL stall_counts: rd=%0d vld=%0d want 2 2", rd_q.size(), vld_q.size());
        end else begin
            n_tests++;
            if (rd_q[0] != a + 1 || rd_q[1] != a + 4 || vld_q[0] != a + 3 || vld_q[1] != a + 6
                || sel0_q[0] !== 4'd5 || sel0_q[1] !== 4'd7) begin
                n_fail++;
                $display("FAIL stall_timing: rd@%0d,%0d vld@%0d,%0d sel0=%0d,%0d want rd@1,4 vld@3,6 sel0=5,7",
                         rd_q[0] - a, rd_q[1] - a, vld_q[0] - a, vld_q[1] - a, sel0_q[0], sel0_q[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int a;
        clear_obs();
        set_cmd(1'b0, 4'd0, 4'd1, 8'd4);
        a = cyc + 1;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (vld_q.size() != 1 || vld_q[0] != a + 3 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_flush: nvld=%0d ndone=%0d, want 1 valid at +3 and no done",
                     vld_q.size(), done_q.size());
        end
        clear_obs();
        set_cmd(1'b0, 4'd9, 4'd1, 8'd1);
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (vld_q.size() != 2 || done_q.size() != 1 || sel0_q.size() != 2 || sel0_q[0] !== 4'd9) begin
            n_fail++;
            $display("FAIL rstmid_rerun: nvld=%0d ndone=%0d, want 2 1", vld_q.size(), done_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int a;
        int target;
        int exp_rd[3]  = '{1, 2, 7};
        int exp_sel[3] = '{2, 7, 9};
        clear_obs();
        set_cmd(1'b0, 4'd2, 4'd5, 8'd1);
        a = cyc + 1;
        target = m_acc + 2;
        cycle(1'b1, 1'b1, 1'b0);
        set_cmd(1'b1, 4'd9, 4'd1, 8'd0);
        for (int i = 0; i < 20 && m_acc < target; i++) cycle(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (m_acc != target) begin
            n_fail++;
            $display("FAIL b2b_accept: accepted=%0d want %0d", m_acc, target);
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (rd_q.size() != 3 || done_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: rd=%0d done=%0d want 3 2", rd_q.size(), done_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (rd_q[i] != a + exp_rd[i] || 32'(sel0_q[i]) != exp_sel[i]) begin
                    n_fail++;
                    $display("FAIL b2b_pass%0d: rd@%0d sel0=%0d want rd@%0d sel0=%0d",
                             i, rd_q[i] - a, sel0_q[i], exp_rd[i], exp_sel[i]);
                end
            end
            n_tests++;
            if (done_q[0] != a + 5 || done_q[1] != a + 10) begin
                n_fail++;
                $display("FAIL b2b_done: done@%0d,%0d want 5,10", done_q[0] - a, done_q[1] - a);
            end
        end
    endtask

    task automatic test_max_passes();
        int a;
        clear_obs();
        set_cmd(1'b0, 4'd0, 4'd7, 8'd255);
        a = cyc + 1;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 262; i++) cycle(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (rd_q.size() != 256 || vld_q.size() != 256 || last_q.size() != 1 || done_q.size() != 1) begin
            n_fail++;
            $display("FAIL max_counts: rd=%0d vld=%0d last=%0d done=%0d want 256 256 1 1",
                     rd_q.size(), vld_q.size(), last_q.size(), done_q.size());
        end else begin
            n_tests++;
            if (tag_q[255] !== 8'd255 || last_q[0] != a + 258 || done_q[0] != a + 259) begin
                n_fail++;
                $display("FAIL max_last: tag=%0d last@%0d done@%0d want 255 258 259",
                         tag_q[255], last_q[0] - a, done_q[0] - a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_wrap_bcast();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_max_passes();
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d passes outstanding want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
